// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two chained line buffers plus a
// column shifter emit every fully-interior 3x3 window of a raster frame.
module sobel_window_3x3 #(
    parameter int DATAWIDTH = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   iStart,
    input  logic [DATAWIDTH-1:0]   iData,
    output logic                   oStart,
    output logic [9*DATAWIDTH-1:0] oWin,
    output logic                   oLast
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    // Release of the async reset is re-timed so all state leaves reset on one edge.
    logic rst_meta_reg;
    logic rst_sync_reg;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    logic accept;
    assign accept = iStart && rst_sync_reg;

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Stage 1: pixel, position flags and line-buffer reads for the accepted pixel.
    logic                 acc_reg;
    logic                 win_ok_reg;
    logic                 last_reg;
    logic [DATAWIDTH-1:0] pix_reg;
    logic [CW-1:0]        col_d_reg;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= 1'b0;
            win_ok_reg <= 1'b0;
            last_reg   <= 1'b0;
            pix_reg    <= '0;
            col_d_reg  <= '0;
        end else begin
            acc_reg <= accept;
            if (accept) begin
                win_ok_reg <= (row_reg >= RW'(2)) && (col_reg >= CW'(2));
                last_reg   <= (row_reg == ROW_MAX) && (col_reg == COL_MAX);
                pix_reg    <= iData;
                col_d_reg  <= col_reg;
            end
        end
    end

    // LB0 takes LB1's old value one cycle late from the registered read; the
    // address it writes is never the one being read since IMG_W >= 3.
    logic [DATAWIDTH-1:0] lb0_mem [0:IMG_W-1];
    logic [DATAWIDTH-1:0] lb1_mem [0:IMG_W-1];
    logic [DATAWIDTH-1:0] top_rd_reg;
    logic [DATAWIDTH-1:0] mid_rd_reg;
    always_ff @(posedge clk_i) begin
        if (accept) begin
            top_rd_reg       <= lb0_mem[col_reg];
            mid_rd_reg       <= lb1_mem[col_reg];
            lb1_mem[col_reg] <= iData;
        end
        if (acc_reg) begin
            lb0_mem[col_d_reg] <= mid_rd_reg;
        end
    end

    // Stage 2: column shifter, element index 3*row+col with col 2 newest.
    logic [DATAWIDTH-1:0] new_col [0:2];
    logic [DATAWIDTH-1:0] sh_reg  [0:8];
    logic [DATAWIDTH-1:0] sh_next [0:8];
    logic [DATAWIDTH-1:0] win_reg [0:8];

    assign new_col[0] = top_rd_reg;
    assign new_col[1] = mid_rd_reg;
    assign new_col[2] = pix_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign sh_next[3*gi]   = sh_reg[3*gi+1];
            assign sh_next[3*gi+1] = sh_reg[3*gi+2];
            assign sh_next[3*gi+2] = new_col[gi];
        end
        for (gi = 0; gi < 9; gi++) begin : g_pack
            assign oWin[DATAWIDTH*gi +: DATAWIDTH] = win_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            oStart <= 1'b0;
            oLast  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                sh_reg[i]  <= '0;
                win_reg[i] <= '0;
            end
        end else begin
            oStart <= acc_reg && win_ok_reg;
            oLast  <= acc_reg && win_ok_reg && last_reg;
            if (acc_reg) begin
                for (int i = 0; i < 9; i++) begin
                    sh_reg[i] <= sh_next[i];
                    if (win_ok_reg) begin
                        win_reg[i] <= sh_next[i];
                    end
                end
            end
        end
    end
endmodule

// File: doc/sobel_window_3x3.md
# sobel_window_3x3

Streaming 3x3 neighbourhood generator placed directly upstream of the `LPL_Sobel` kernel. It accepts one raster-order pixel per valid cycle and holds the two previous image lines in internal line buffers. For every pixel whose full 3x3 neighbourhood lies inside the frame, it emits all nine pixels in parallel with a valid strobe. It also flags the last window of each frame so downstream logic can close output files and counters.

## Interface
- `DATAWIDTH`, 8: pixel width in bits.
- `IMG_W`, 640: pixels per line; minimum 3.
- `IMG_H`, 480: lines per frame; minimum 3.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `iStart`  in  1  input pixel valid; one pixel is accepted per rising edge with `iStart`=1.
- `iData`  in  DATAWIDTH  input pixel, raster order (row-major, top-left first).
- `oStart`  out  1  window valid strobe.
- `oWin`  out  9*DATAWIDTH  window; element k = 3*row+col occupies bits [DATAWIDTH*k +: DATAWIDTH]; row 0 = oldest line, col 0 = oldest column, k=8 = newest pixel.
- `oLast`  out  1  high together with `oStart` for the final window of a frame.

## Operation
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) advance only on accepted pixels.
  - `col` wraps to 0 at IMG_W-1, and `row` then increments.
  - At row=IMG_H-1, col=IMG_W-1 both wrap to 0; the next accepted pixel is (0,0) of a new frame. Frames are back-to-back with no gap required.
- Two line buffers, each IMG_W deep and DATAWIDTH wide, chained.
  - On an accepted pixel at column c: LB1[c] is read as the pixel one line above and LB0[c] as the pixel two lines above.
  - The same cycle writes LB0[c] <= LB1[c] and LB1[c] <= iData (read-before-write).
- Three column-shift stages of 3 pixels each (top, mid, bottom) shift only on accepted pixels. The newest column = {LB0[c], LB1[c], iData}.
- Window valid condition for the accepted pixel at (row, col): row>=2 and col>=2. The window is then centred on (row-1, col-1).
  - No border padding. Each frame yields exactly (IMG_H-2)*(IMG_W-2) windows; 304964 at default size.
- Windows never mix frames. Line-buffer contents from the previous frame are overwritten before row 2 of the new frame and are never emitted.
- `oLast` = valid window at row=IMG_H-1, col=IMG_W-1.
- `iStart` low: counters, line buffers and shift stages hold. Gaps of any length at any position (mid-line, line end, frame end) are transparent; output content is identical to gapless input.

## Timing
- Reset (async assert): `oStart`=0, `oLast`=0, `oWin`=0, row=col=0, shift stages=0. Line-buffer contents are don't-care. Deassertion is used synchronously via internal sync of the release.
- Latency: pixel accepted at edge N → `oWin`/`oStart`/`oLast` registered and valid after edge N+1. The strobe is high for exactly one cycle per window.
  - Line-buffer read at edge N (synchronous RAM allowed); window register at edge N+1.
- Throughput: one window per clock with sustained `iStart`=1. There is no backpressure; downstream must accept every strobe.
- `oWin` holds its last value while `oStart`=0.
- Reset mid-frame: output strobes stop immediately. The next accepted pixel after release is treated as (0,0) of a new frame, and no window containing pre-reset pixels is ever emitted.

## Test plan
- IMG_W=5, IMG_H=4; pixel (r,c)=16r+c; continuous `iStart` for 20 pixels → 6 strobes. First window oWin k0..k8 = 00,01,02,10,11,12,20,21,22, strobed 2 cycles after accepting pixel 0x22. Last window ends with 0x34, `oLast`=1 on it only.
- Same frame with `iStart` deasserted for 1, 3 and 7 cycles at col 0, col 2 and line end → identical 6 windows in the same order. No strobe during gaps; `oWin` stable during gaps.
- Two back-to-back 5x4 frames, second frame values +0x80 → 12 strobes. Second frame's first window = 80,81,82,90,91,92,A0,A1,A2, with no first-frame values present. `oLast` pulses twice.
- Assert `rst_n`=0 asynchronously mid-row 2, then release and send a full frame → outputs go to 0 immediately. Exactly 6 correct windows follow, none containing pre-reset data.
- Defaults 640x480 ramp (pixel = addr mod 256), continuous → 304964 strobes. Each window checked against a reference model. `oLast` is on the final strobe, 2 cycles after the last input pixel.
